// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, 2-entry skid buffer
// and per-thread selective flush. Define PIPE_STATS_EN to add stall/flush counters.
module pipe_stage_reg #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 64,
   parameter int DEST_W   = 5,
   parameter int WB_W     = 2,
   parameter int NTHREADS = 4,
   parameter int TID_W    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_mem_ctrl,
   input  logic [WB_W-1:0]     in_wb_ctrl,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DEST_W-1:0]   in_dest,
   input  logic [TID_W-1:0]    in_tid,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_mem_ctrl,
   output logic [WB_W-1:0]     out_wb_ctrl,
   output logic [DATA_W-1:0]   out_data,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [DEST_W-1:0]   out_dest,
   output logic [TID_W-1:0]    out_tid,
   input  logic                flush_en,
   input  logic [NTHREADS-1:0] flush_mask
`ifdef PIPE_STATS_EN
   ,
   input  logic                stat_clr,
   output logic [31:0]         stat_stall,
   output logic [31:0]         stat_flush
`endif
);

   localparam int BEAT_W = 1 + WB_W + DATA_W + ADDR_W + DEST_W + TID_W;

   logic [BEAT_W-1:0] m_beat_reg, s_beat_reg, in_beat;
   logic              m_v_reg, s_v_reg, in_ready_reg;
   logic              m_v_next, s_v_next;
   logic              m_load_s, m_load_in, s_load_in;
   logic [TID_W-1:0]  m_tid, s_tid;
   logic              kill_m, kill_s, kill_in;
   logic              acc, acc_live, m_free;

   assign in_beat = {in_mem_ctrl, in_wb_ctrl, in_data, in_addr, in_dest, in_tid};
   assign m_tid   = m_beat_reg[TID_W-1:0];
   assign s_tid   = s_beat_reg[TID_W-1:0];

   assign kill_m  = flush_en & flush_mask[m_tid];
   assign kill_s  = flush_en & flush_mask[s_tid];
   assign kill_in = flush_en & flush_mask[in_tid];

   assign in_ready  = in_ready_reg;
   assign acc       = in_valid & in_ready_reg;
   assign acc_live  = acc & ~kill_in;
   assign out_valid = m_v_reg & ~kill_m;
   // A killed main entry frees the slot even though it never transfers downstream.
   assign m_free    = ~m_v_reg | (out_ready & out_valid) | kill_m;

   assign {out_mem_ctrl, out_wb_ctrl, out_data, out_addr, out_dest, out_tid} = m_beat_reg;

   always_comb begin
      m_v_next  = m_v_reg;
      s_v_next  = s_v_reg;
      m_load_s  = 1'b0;
      m_load_in = 1'b0;
      s_load_in = 1'b0;
      if (m_free && s_v_reg && !kill_s) begin
         m_v_next  = 1'b1;
         m_load_s  = 1'b1;
         s_v_next  = acc_live;
         s_load_in = acc_live;
      end else if (m_free) begin
         m_v_next  = acc_live;
         m_load_in = acc_live;
         s_v_next  = 1'b0;
      end else begin
         if (kill_s)
            s_v_next = 1'b0;
         if (acc_live) begin
            s_v_next  = 1'b1;
            s_load_in = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_v_reg      <= 1'b0;
         s_v_reg      <= 1'b0;
         in_ready_reg <= 1'b1;
         m_beat_reg   <= '0;
         s_beat_reg   <= '0;
      end else begin
         m_v_reg      <= m_v_next;
         s_v_reg      <= s_v_next;
         // Registered copy of !s_v: a full skid entry blocks input from the next cycle on.
         in_ready_reg <= ~s_v_next;
         if (m_load_s)
            m_beat_reg <= s_beat_reg;
         else if (m_load_in)
            m_beat_reg <= in_beat;
         if (s_load_in)
            s_beat_reg <= in_beat;
      end
   end

`ifdef PIPE_STATS_EN
   logic [31:0] stat_stall_reg, stat_flush_reg;
   logic [32:0] stall_sum, flush_sum;
   logic [1:0]  flush_inc;
   logic        stall_inc;

   assign stall_inc = out_valid & ~out_ready;
   assign flush_inc = 2'(m_v_reg & kill_m) + 2'(s_v_reg & kill_s) + 2'(acc & kill_in);
   assign stall_sum = {1'b0, stat_stall_reg} + 33'(stall_inc);
   assign flush_sum = {1'b0, stat_flush_reg} + 33'(flush_inc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_stall_reg <= '0;
         stat_flush_reg <= '0;
      end else if (stat_clr) begin
         stat_stall_reg <= '0;
         stat_flush_reg <= '0;
      end else begin
         stat_stall_reg <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
         stat_flush_reg <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
      end
   end

   assign stat_stall = stat_stall_reg;
   assign stat_flush = stat_flush_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, flush and
// reset-mid-operation, plus counters when PIPE_STATS_EN is defined.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_mem_ctrl;
   logic [1:0]  in_wb_ctrl;
   logic [63:0] in_data, in_addr;
   logic [4:0]  in_dest;
   logic [1:0]  in_tid;
   logic        out_valid, out_ready, out_mem_ctrl;
   logic [1:0]  out_wb_ctrl;
   logic [63:0] out_data, out_addr;
   logic [4:0]  out_dest;
   logic [1:0]  out_tid;
   logic        flush_en;
   logic [3:0]  flush_mask;
`ifdef PIPE_STATS_EN
   logic        stat_clr;
   logic [31:0] stat_stall, stat_flush;
`endif

   int checks = 0;
   int errors = 0;
   int xfer_cnt = 0;
   int xfer_saved;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mem_ctrl(in_mem_ctrl),
      .in_wb_ctrl(in_wb_ctrl), .in_data(in_data), .in_addr(in_addr),
      .in_dest(in_dest), .in_tid(in_tid),
      .out_valid(out_valid), .out_ready(out_ready), .out_mem_ctrl(out_mem_ctrl),
      .out_wb_ctrl(out_wb_ctrl), .out_data(out_data), .out_addr(out_addr),
      .out_dest(out_dest), .out_tid(out_tid),
      .flush_en(flush_en), .flush_mask(flush_mask)
`ifdef PIPE_STATS_EN
      , .stat_clr(stat_clr), .stat_stall(stat_stall), .stat_flush(stat_flush)
`endif
   );

   // Downstream view: a transfer is out_valid & out_ready at a clock edge.
   always @(posedge clk)
      if (rst && out_valid && out_ready)
         xfer_cnt <= xfer_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [63:0] d, input logic [1:0] t);
      in_valid = 1'b1;
      in_data  = d;
      in_addr  = d + 64'h100;
      in_tid   = t;
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b1; in_mem_ctrl = 1'b1; in_wb_ctrl = 2'b10;
      in_data = 64'hDEAD; in_addr = 64'h0; in_dest = 5'd7; in_tid = 2'd0;
      out_ready = 1'b1; flush_en = 1'b0; flush_mask = 4'b0000;
`ifdef PIPE_STATS_EN
      stat_clr = 1'b0;
`endif
      tick(); tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_data", out_data, 64'd0);

      // release and accept the first beat
      rst = 1'b1;
      send(64'h11, 2'd0);
      tick();
      in_valid = 1'b0;
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("first_data", out_data, 64'h11);
      chk("first_addr", out_addr, 64'h111);
      chk("first_dest", 64'(out_dest), 64'd7);
      tick();
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("empty_hold_data", out_data, 64'h11);

      // streaming 1..8
      for (int i = 1; i <= 8; i++) begin
         send(64'(i), 2'd0);
         tick();
         chk($sformatf("stream_data%0d", i), out_data, 64'(i));
         chk($sformatf("stream_rdy%0d", i), 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_end_valid", 64'(out_valid), 64'd0);

      // backpressure
      out_ready = 1'b0;
      send(64'hA, 2'd0);
      tick();
      chk("bp_a_valid", 64'(out_valid), 64'd1);
      chk("bp_rdy_after_a", 64'(in_ready), 64'd1);
      send(64'hB, 2'd0);
      tick();
      chk("bp_rdy_after_b", 64'(in_ready), 64'd0);
      chk("bp_hold_a", out_data, 64'hA);
      send(64'hC, 2'd0);
      tick();
      chk("bp_still_a", out_data, 64'hA);
      chk("bp_still_full", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_b_out", out_data, 64'hB);
      chk("bp_b_valid", 64'(out_valid), 64'd1);
      chk("bp_rdy_back", 64'(in_ready), 64'd1);
      tick();
      chk("bp_no_dup", 64'(out_valid), 64'd0);

      // selective flush: M tid1, S tid2, input tid1, mask 0010
      out_ready = 1'b0;
      send(64'hD1, 2'd1);
      tick();
      send(64'hD2, 2'd2);
      tick();
      send(64'hD3, 2'd1);
      flush_en = 1'b1; flush_mask = 4'b0010;
      #1;
      chk("fl_m_masked", 64'(out_valid), 64'd0);
      tick();
      flush_en = 1'b0; in_valid = 1'b0;
      chk("fl_s_promoted", out_data, 64'hD2);
      chk("fl_s_tid", 64'(out_tid), 64'd2);
      chk("fl_s_valid", 64'(out_valid), 64'd1);
      chk("fl_s_emptied", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      tick();
      chk("fl_in_dropped", 64'(out_valid), 64'd0);

      // killed input on empty stage is consumed and discarded
      send(64'hD4, 2'd1);
      flush_en = 1'b1; flush_mask = 4'b0010;
      #1;
      chk("kin_ready", 64'(in_ready), 64'd1);
      tick();
      flush_en = 1'b0; in_valid = 1'b0;
      chk("kin_dropped", 64'(out_valid), 64'd0);
      chk("kin_stale_data", out_data, 64'hD2);

      // flush with out_ready on matching tid 3
      send(64'hE, 2'd3);
      tick();
      in_valid = 1'b0;
      chk("f3_valid", 64'(out_valid), 64'd1);
      flush_en = 1'b1; flush_mask = 4'b1000;
      #1;
      chk("f3_masked", 64'(out_valid), 64'd0);
      xfer_saved = xfer_cnt;
      tick();
      flush_en = 1'b0;
      chk("f3_no_xfer", 64'(xfer_cnt), 64'(xfer_saved));
      chk("f3_invalidated", 64'(out_valid), 64'd0);

      // all-ones mask empties both entries
      out_ready = 1'b0;
      send(64'hF0, 2'd0);
      tick();
      send(64'hF3, 2'd3);
      tick();
      in_valid = 1'b0;
      chk("fa_full", 64'(in_ready), 64'd0);
      flush_en = 1'b1; flush_mask = 4'b1111;
      tick();
      flush_en = 1'b0;
      chk("fa_m_empty", 64'(out_valid), 64'd0);
      chk("fa_s_empty", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      tick();
      chk("fa_stays_empty", 64'(out_valid), 64'd0);

      // reset mid-operation
      out_ready = 1'b0;
      send(64'h51, 2'd0);
      tick();
      send(64'h52, 2'd1);
      tick();
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_data", out_data, 64'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_empty", 64'(out_valid), 64'd0);

`ifdef PIPE_STATS_EN
      chk("st_rst_stall", 64'(stat_stall), 64'd0);
      send(64'h61, 2'd0);
      tick();
      send(64'h62, 2'd1);
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("st_stall5", 64'(stat_stall), 64'd5);
      flush_en = 1'b1; flush_mask = 4'b0011;
      tick();
      flush_en = 1'b0;
      chk("st_stall_kept", 64'(stat_stall), 64'd5);
      chk("st_flush2", 64'(stat_flush), 64'd2);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("st_clr_stall", 64'(stat_stall), 64'd0);
      chk("st_clr_flush", 64'(stat_flush), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
